lsu_riscv: RTL and testbench
============================

# lsu_riscv

Load/store unit between the decoder/ALU of the single-cycle RISC-V core and the data memory bus. It turns a core memory request into a word-aligned bus transaction with byte enables, stalls the core until the bus acknowledges, and returns loads sign- or zero-extended. Its `core_stall_req_o` drives the decoder's `lsu_stall_req_i`, which gates PC advance and register write-back.

## Interface
- No parameters; data and address widths are fixed at 32.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `core_req_i` in 1: memory instruction present (decoder `mem_req_o`).
- `core_we_i` in 1: 1 = store, 0 = load.
- `core_size_i` in 3: funct3 size code: B=0, H=1, W=2, BU=4, HU=5.
- `core_addr_i` in 32: byte address (ALU result).
- `core_wd_i` in 32: store data (rs2).
- `core_stall_req_o` out 1: hold PC and write-back.
- `core_rd_o` out 32: extended load result.
- `core_misalign_o` out 1: misaligned address or invalid size; no access is made.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: bus write.
- `mem_be_o` out 4: byte enables.
- `mem_addr_o` out 32: word address, `{addr[31:2],2'b00}`.
- `mem_wd_o` out 32: lane-replicated write data.
- `mem_rd_i` in 32: bus read word.
- `mem_ack_i` in 1: one-cycle completion strobe.

## Operation
- FSM has three states.
  - IDLE → BUSY when `core_req_i` is high and the access is legal. The address, byte enables, write data, write flag and size are registered on this transition.
  - BUSY → DONE on `mem_ack_i`. A load captures `mem_rd_i` on this edge.
  - DONE → IDLE unconditionally.
- `core_stall_req_o` is high in these cases:
  - combinationally in IDLE when `core_req_i` is high and the access is legal;
  - always in BUSY.
  - It is low in DONE, so the core retires the instruction in that cycle.
- Misalignment rules:
  - H/HU with `addr[0]`=1 is misaligned.
  - W with `addr[1:0]`≠0 is misaligned.
  - Sizes 3, 6 and 7 are invalid.
  - In all these cases `core_misalign_o`=1 combinationally in IDLE, there is no stall, no bus access, and the FSM stays in IDLE.
- Byte enables:
  - B: `4'b0001 << addr[1:0]`.
  - H: `4'b0011 << {addr[1],1'b0}`.
  - W: `4'b1111`.
  - Loads drive the same enables.
- Write data:
  - B: `{4{wd[7:0]}}`.
  - H: `{2{wd[15:0]}}`.
  - W: `wd`.
- Load extraction selects the byte or halfword by the registered `addr[1:0]`.
  - B and H sign-extend.
  - BU and HU zero-extend.
  - W passes the word through.
- `core_rd_o` is a register. It updates only on a load ack and holds its value through stores and idle cycles.
- Ignored events:
  - `mem_ack_i` outside BUSY.
  - Changes on `core_*` inputs during BUSY and DONE (the registered copy is used).
  - A dropped `core_req_i` during BUSY: the transaction still completes.
- Reset at any point: the FSM goes to IDLE and all registered outputs clear immediately. An in-flight transaction is abandoned and a late ack is ignored.

## Timing
- Reset values:
  - `mem_req_o`=0, `mem_we_o`=0, `mem_be_o`=0, `mem_addr_o`=0, `mem_wd_o`=0.
  - `core_rd_o`=0.
  - `core_stall_req_o`=0 and `core_misalign_o`=0 while `core_req_i`=0.
- Cycle t: request seen in IDLE, stall=1.
- Cycle t+1: BUSY, `mem_req_o`=1 from a register, with address, enables and data stable.
- `mem_req_o` and all bus outputs are held constant until the cycle in which ack is sampled. They drop on the next edge.
- With ack at t+1: DONE at t+2, stall=0, `core_rd_o` valid. The minimum access is 3 cycles, with 2 stalled cycles.
- With ack at t+1+N: completion is N cycles later. There is no timeout.
- Back-to-back accesses: the next request is accepted in the IDLE cycle after DONE.

## Structure
- Shared package `riscv_pkg`:
  - LDST size constants, which must match the decoder `mem_size_o` encoding;
  - `lsu_state_t` enum {IDLE, BUSY, DONE}.
- Sub-module `lsu_load_align` (combinational): inputs `mem_rd_i`, `addr[1:0]`, size; output is the 32-bit extended result.
- The top level holds the FSM, request registers, enable and replication logic, and the `core_rd_o` register.

## Test plan
- LW at 0x100, memory word 0x8899AABB, ack one cycle after `mem_req_o` rises:
  - `mem_addr_o`=0x100, `mem_be_o`=1111, stall high for 2 cycles;
  - `core_rd_o`=0x8899AABB in DONE.
- LB and LBU at 0x103 on the same word:
  - `mem_be_o`=1000;
  - LB gives 0xFFFFFF88, LBU gives 0x00000088.
- SH at 0x202 with wd=0x1234ABCD:
  - `mem_we_o`=1, `mem_be_o`=1100, `mem_wd_o`=0xABCDABCD, `mem_addr_o`=0x200;
  - `core_rd_o` unchanged.
- LW at 0x101, and separately size=3:
  - `core_misalign_o`=1, stall 0, `mem_req_o` never asserted.
- Ack delayed 5 cycles:
  - bus outputs constant throughout, stall high for 6 cycles.
  - Variant: `rst_i` pulsed in BUSY, then a stray ack arrives. `mem_req_o` drops asynchronously, the FSM is IDLE, and `core_rd_o`=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core: memory access size
// codes (funct3, as emitted by the decoder on mem_size_o) and LSU states.
package riscv_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a bus read word and extends it
// to 32 bits according to the load size.
module lsu_load_align
   import riscv_pkg::*;
(
   input  logic [31:0] mem_rd_i,
   input  logic [1:0]  addr_i,
   input  logic [2:0]  size_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // lane select followed by sign/zero extension
   always_comb begin
      byte_sel = mem_rd_i[7:0];
      case (addr_i)
         2'd1:    byte_sel = mem_rd_i[15:8];
         2'd2:    byte_sel = mem_rd_i[23:16];
         2'd3:    byte_sel = mem_rd_i[31:24];
         default: byte_sel = mem_rd_i[7:0];
      endcase
      half_sel = addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

      case (size_i)
         LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
         LDST_BU: data_o = {24'd0, byte_sel};
         LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
         LDST_HU: data_o = {16'd0, half_sel};
         default: data_o = mem_rd_i;
      endcase
   end

endmodule

// File: rtl/lsu_riscv.sv
// Load/store unit: converts a core memory request into a word-aligned bus
// transaction, stalls the core until ack, and returns extended load data.
//
// state | meaning
// IDLE  | waiting for a legal core request (stall is combinational here)
// BUSY  | bus request held, waiting for mem_ack_i
// DONE  | access finished, stall released so the core retires the instr
module lsu_riscv
   import riscv_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        core_req_i,
   input  logic        core_we_i,
   input  logic [2:0]  core_size_i,
   input  logic [31:0] core_addr_i,
   input  logic [31:0] core_wd_i,
   output logic        core_stall_req_o,
   output logic [31:0] core_rd_o,
   output logic        core_misalign_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wd_o,
   input  logic [31:0] mem_rd_i,
   input  logic        mem_ack_i
);

   lsu_state_t  state_q, state_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wd_q, mem_wd_d;
   logic [2:0]  size_q, size_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] core_rd_q, core_rd_d;

   logic        legal;
   logic [3:0]  be_new;
   logic [31:0] wd_new;
   logic [31:0] load_data;

   lsu_load_align u_load_align (
      .mem_rd_i (mem_rd_i),
      .addr_i   (off_q),
      .size_i   (size_q),
      .data_o   (load_data)
   );

   // legality, byte enables and lane replication for the incoming request
   always_comb begin
      legal  = 1'b0;
      be_new = 4'b0000;
      wd_new = core_wd_i;
      case (core_size_i)
         LDST_B, LDST_BU: begin
            legal  = 1'b1;
            be_new = 4'b0001 << core_addr_i[1:0];
            wd_new = {4{core_wd_i[7:0]}};
         end
         LDST_H, LDST_HU: begin
            legal  = ~core_addr_i[0];
            be_new = 4'b0011 << {core_addr_i[1], 1'b0};
            wd_new = {2{core_wd_i[15:0]}};
         end
         LDST_W: begin
            legal  = (core_addr_i[1:0] == 2'b00);
            be_new = 4'b1111;
         end
         default: begin
            legal  = 1'b0;
            be_new = 4'b0000;
         end
      endcase
   end

   // next-state, request capture and stall/misalign outputs
   always_comb begin
      state_d          = state_q;
      mem_req_d        = mem_req_q;
      mem_we_d         = mem_we_q;
      mem_be_d         = mem_be_q;
      mem_addr_d       = mem_addr_q;
      mem_wd_d         = mem_wd_q;
      size_d           = size_q;
      off_d            = off_q;
      core_rd_d        = core_rd_q;
      core_stall_req_o = 1'b0;
      core_misalign_o  = 1'b0;
      case (state_q)
         IDLE: begin
            if (core_req_i) begin
               if (legal) begin
                  core_stall_req_o = 1'b1;
                  state_d          = BUSY;
                  mem_req_d        = 1'b1;
                  mem_we_d         = core_we_i;
                  mem_be_d         = be_new;
                  mem_addr_d       = {core_addr_i[31:2], 2'b00};
                  mem_wd_d         = wd_new;
                  size_d           = core_size_i;
                  off_d            = core_addr_i[1:0];
               end else begin
                  core_misalign_o = 1'b1;
               end
            end
         end
         BUSY: begin
            core_stall_req_o = 1'b1;
            if (mem_ack_i) begin
               state_d    = DONE;
               mem_req_d  = 1'b0;
               mem_we_d   = 1'b0;
               mem_be_d   = 4'b0000;
               mem_addr_d = 32'd0;
               mem_wd_d   = 32'd0;
               if (!mem_we_q) core_rd_d = load_data;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state and request registers; reset abandons any in-flight access
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_be_q   <= 4'b0000;
         mem_addr_q <= 32'd0;
         mem_wd_q   <= 32'd0;
         size_q     <= 3'd0;
         off_q      <= 2'd0;
         core_rd_q  <= 32'd0;
      end else begin
         state_q    <= state_d;
         mem_req_q  <= mem_req_d;
         mem_we_q   <= mem_we_d;
         mem_be_q   <= mem_be_d;
         mem_addr_q <= mem_addr_d;
         mem_wd_q   <= mem_wd_d;
         size_q     <= size_d;
         off_q      <= off_d;
         core_rd_q  <= core_rd_d;
      end
   end

   assign mem_req_o  = mem_req_q;
   assign mem_we_o   = mem_we_q;
   assign mem_be_o   = mem_be_q;
   assign mem_addr_o = mem_addr_q;
   assign mem_wd_o   = mem_wd_q;
   assign core_rd_o  = core_rd_q;

endmodule

// File: tb/tb_lsu_riscv.sv
// Bench for lsu_riscv: directed accesses from the bring-up list, then random
// loads/stores with random ack delay, checked against a behavioural model.
module tb_lsu_riscv;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        core_req_i, core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i, core_wd_i;
   logic        core_stall_req_o, core_misalign_o;
   logic [31:0] core_rd_o;
   logic        mem_req_o, mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o, mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ack_i;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] model_rd = 32'd0;

   lsu_riscv dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .core_req_i       (core_req_i),
      .core_we_i        (core_we_i),
      .core_size_i      (core_size_i),
      .core_addr_i      (core_addr_i),
      .core_wd_i        (core_wd_i),
      .core_stall_req_o (core_stall_req_o),
      .core_rd_o        (core_rd_o),
      .core_misalign_o  (core_misalign_o),
      .mem_req_o        (mem_req_o),
      .mem_we_o         (mem_we_o),
      .mem_be_o         (mem_be_o),
      .mem_addr_o       (mem_addr_o),
      .mem_wd_o         (mem_wd_o),
      .mem_rd_i         (mem_rd_i),
      .mem_ack_i        (mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // reference rules, stated in terms of access width and byte offset
   function automatic int nbytes(input logic [2:0] size);
      case (size)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic bit m_legal(input logic [2:0] size, input logic [31:0] addr);
      int n = nbytes(size);
      if (n == 0) return 1'b0;
      return (addr % n) == 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] size, input logic [31:0] addr);
      int n   = nbytes(size);
      int off = int'(addr % 4);
      logic [3:0] be = 4'b0000;
      for (int i = 0; i < n; i++) be[off + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] size, input logic [31:0] wd);
      int n = nbytes(size);
      logic [31:0] r = 32'd0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] size, input logic [31:0] addr,
                                          input logic [31:0] word);
      int          n   = nbytes(size);
      logic [31:0] v   = word >> (8 * (addr % 4));
      bit          sgn = (size == 3'd0) || (size == 3'd1);
      if (n == 4) return word;
      v = v & ((32'd1 << (8 * n)) - 32'd1);
      if (sgn && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   task automatic do_txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata, input int dly,
                         input bit scramble);
      int          stalls;
      logic [3:0]  exp_be = m_be(size, addr);
      logic [31:0] exp_wd = m_wd(size, wd);
      core_req_i  = 1'b1;
      core_we_i   = we;
      core_size_i = size;
      core_addr_i = addr;
      core_wd_i   = wd;
      #1;
      if (!m_legal(size, addr)) begin
         chk("misalign", 32'(core_misalign_o), 32'd1);
         chk("misalign_stall", 32'(core_stall_req_o), 32'd0);
         tick();
         chk("misalign_noreq", 32'(mem_req_o), 32'd0);
         chk("misalign_hold", 32'(core_misalign_o), 32'd1);
         core_req_i = 1'b0;
         tick();
         chk("misalign_noreq2", 32'(mem_req_o), 32'd0);
         chk("misalign_rd", core_rd_o, model_rd);
         return;
      end
      chk("legal_nomis", 32'(core_misalign_o), 32'd0);
      chk("idle_stall", 32'(core_stall_req_o), 32'd1);
      stalls = int'(core_stall_req_o);
      tick();
      for (int c = 0; c <= dly; c++) begin
         if (scramble) begin
            core_req_i  = 1'($urandom);
            core_we_i   = 1'($urandom);
            core_size_i = 3'($urandom);
            core_addr_i = $urandom;
            core_wd_i   = $urandom;
            #1;
         end
         chk("busy_req", 32'(mem_req_o), 32'd1);
         chk("busy_we", 32'(mem_we_o), 32'(we));
         chk("busy_be", 32'(mem_be_o), 32'(exp_be));
         chk("busy_addr", mem_addr_o, {addr[31:2], 2'b00});
         if (we) chk("busy_wd", mem_wd_o, exp_wd);
         stalls += int'(core_stall_req_o);
         if (c == dly) begin
            mem_ack_i = 1'b1;
            mem_rd_i  = rdata;
         end else begin
            mem_rd_i  = $urandom;
         end
         tick();
      end
      mem_ack_i  = 1'b0;
      core_req_i = 1'b0;
      mem_rd_i   = ~rdata;
      if (!we) model_rd = m_load(size, addr, rdata);
      #1;
      chk("done_stall", 32'(core_stall_req_o), 32'd0);
      chk("done_req", 32'(mem_req_o), 32'd0);
      chk("done_rd", core_rd_o, model_rd);
      chk("stall_cycles", 32'(stalls), 32'(2 + dly));
      // stray ack in DONE must not reload core_rd_o
      mem_ack_i = 1'b1;
      tick();
      mem_ack_i = 1'b0;
      chk("stray_ack_rd", core_rd_o, model_rd);
      chk("idle_req", 32'(mem_req_o), 32'd0);
   endtask

   initial begin
      rst_i       = 1'b1;
      core_req_i  = 1'b0;
      core_we_i   = 1'b0;
      core_size_i = 3'd0;
      core_addr_i = 32'd0;
      core_wd_i   = 32'd0;
      mem_rd_i    = 32'd0;
      mem_ack_i   = 1'b0;
      #2;
      chk("rst_req", 32'(mem_req_o), 32'd0);
      chk("rst_we", 32'(mem_we_o), 32'd0);
      chk("rst_be", 32'(mem_be_o), 32'd0);
      chk("rst_addr", mem_addr_o, 32'd0);
      chk("rst_wd", mem_wd_o, 32'd0);
      chk("rst_rd", core_rd_o, 32'd0);
      chk("rst_stall", 32'(core_stall_req_o), 32'd0);
      chk("rst_mis", 32'(core_misalign_o), 32'd0);
      tick();
      rst_i = 1'b0;
      tick();

      // directed bring-up accesses
      do_txn(1'b0, 3'd2, 32'h100, 32'h0, 32'h8899AABB, 0, 1'b0);
      chk("lw_const", core_rd_o, 32'h8899AABB);
      do_txn(1'b0, 3'd0, 32'h103, 32'h0, 32'h8899AABB, 0, 1'b0);
      chk("lb_const", core_rd_o, 32'hFFFFFF88);
      do_txn(1'b0, 3'd4, 32'h103, 32'h0, 32'h8899AABB, 0, 1'b0);
      chk("lbu_const", core_rd_o, 32'h00000088);
      do_txn(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'hDEADBEEF, 0, 1'b0);
      chk("sh_rd_kept", core_rd_o, 32'h00000088);
      do_txn(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1'b0);
      do_txn(1'b0, 3'd3, 32'h100, 32'h0, 32'h0, 0, 1'b0);
      do_txn(1'b0, 3'd5, 32'h302, 32'h0, 32'h8001C0DE, 4, 1'b1);
      chk("lhu_const", core_rd_o, 32'h00008001);

      // random accesses, including illegal sizes/offsets and noisy inputs
      for (int i = 0; i < 60; i++) begin
         do_txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 4)), 1'($urandom));
      end

      // reset during BUSY abandons the access; a late ack is ignored
      core_req_i  = 1'b1;
      core_we_i   = 1'b0;
      core_size_i = 3'd2;
      core_addr_i = 32'h40;
      tick();
      core_req_i = 1'b0;
      chk("rb_busy", 32'(mem_req_o), 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("rb_req_async", 32'(mem_req_o), 32'd0);
      chk("rb_be_async", 32'(mem_be_o), 32'd0);
      chk("rb_rd_async", core_rd_o, 32'd0);
      chk("rb_stall", 32'(core_stall_req_o), 32'd0);
      rst_i = 1'b0;
      model_rd = 32'd0;
      tick();
      mem_ack_i = 1'b1;
      mem_rd_i  = 32'h12345678;
      tick();
      mem_ack_i = 1'b0;
      chk("rb_late_ack_rd", core_rd_o, 32'd0);
      chk("rb_late_ack_req", 32'(mem_req_o), 32'd0);
      chk("rb_late_ack_stall", 32'(core_stall_req_o), 32'd0);
      do_txn(1'b0, 3'd1, 32'h0A6, 32'h0, 32'h9ABC5678, 1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
